// File: rtl/sfifo_stream_reader.sv
// sfifo_stream_reader: read-side adapter for the single-clock FIFO (sfifo).
// Pops the FIFO through rinc, absorbs the one-cycle registered RAM read
// latency with a two-entry head/skid buffer, and presents the words as a
// valid/ready stream framed every BURST words by m_last.
module sfifo_stream_reader #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             rempty,
    output logic             rinc,
    input  logic [WIDTH-1:0] rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    localparam int            FW    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [FW-1:0] FLAST = FW'(BURST - 1);

    // Buffer state: occ counts valid entries (0..2), head is the presented word.
    logic [1:0]       occ;
    logic             inflight;
    logic [FW-1:0]    fcnt;
    logic [WIDTH-1:0] head_data;
    logic             head_last;
    logic [WIDTH-1:0] skid_data;
    logic             skid_last;

    logic             pop;
    logic             wr_last;
    logic [2:0]       level;

    // Stream outputs come straight from registers, so m_ready never reaches m_valid.
    always_comb begin
        m_valid = (occ != 2'd0);
        m_data  = head_data;
        m_last  = head_last;
    end

    // Pop request: only when the buffer can still hold every word already
    // committed (buffered + in flight) after this cycle's pop.
    always_comb begin
        pop     = m_valid && m_ready;
        wr_last = (fcnt == FLAST);
        level   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        rinc    = rst_n && en && !rempty && (level <= 3'd1);
    end

    // Capture landing words into head/skid, shift skid forward on pop, track framing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= '0;
            inflight  <= 1'b0;
            fcnt      <= '0;
            head_data <= '0;
            head_last <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
        end else begin
            inflight <= rinc;

            if (inflight) begin
                fcnt <= wr_last ? '0 : fcnt + FW'(1);
            end

            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= rdata;
                        head_last <= wr_last;
                    end else begin
                        skid_data <= rdata;
                        skid_last <= wr_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b11: begin
                    // With two entries the skid moves up and the new word
                    // takes its place; with one, the new word replaces head.
                    if (occ == 2'd1) begin
                        head_data <= rdata;
                        head_last <= wr_last;
                    end else begin
                        head_data <= skid_data;
                        head_last <= skid_last;
                        skid_data <= rdata;
                        skid_last <= wr_last;
                    end
                end
                2'b01: begin
                    if (occ == 2'd2) begin
                        head_data <= skid_data;
                        head_last <= skid_last;
                    end
                    occ <= occ - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Buffer occupancy never leaves 0..2.
    a_occ_range: assert property (@(posedge clk) disable iff (!rst_n) occ <= 2'd2);

    // A landing word always finds a free entry.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(inflight && !pop && (occ == 2'd2)));

    // The FIFO RAM read is not gated by empty, so a pop on empty would corrupt it.
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(rinc && rempty));

endmodule

// File: tb/tb_sfifo_stream_reader.sv
// Bench for sfifo_stream_reader: a behavioural FIFO drives the reader, and a
// scoreboard compares the stream against the written word order and the
// frame position (every BURST-th accepted word carries m_last).
module tb_sfifo_stream_reader;

    localparam int W   = 8;
    localparam int B   = 4;
    localparam int SBN = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, en, rempty, rinc, m_valid, m_ready, m_last;
    logic [W-1:0] rdata, m_data;
    logic         en2, rempty2, rinc2, m_valid2, m_ready2, m_last2;
    logic [15:0]  rdata2, m_data2;

    int checks = 0;
    int errors = 0;

    sfifo_stream_reader #(.WIDTH(W), .BURST(B)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rempty(rempty), .rinc(rinc),
        .rdata(rdata), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    sfifo_stream_reader #(.WIDTH(16), .BURST(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .rempty(rempty2), .rinc(rinc2),
        .rdata(rdata2), .m_valid(m_valid2), .m_ready(m_ready2),
        .m_data(m_data2), .m_last(m_last2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural 64-deep FIFO with registered read data, plus the
    // scoreboard record of every word written.
    logic [W-1:0] fmem [64];
    logic [W-1:0] exp_mem [SBN];
    int           wptr, rptr, widx;
    logic         wr_en;
    logic [W-1:0] wr_data;

    assign rempty = (wptr == rptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= 0;
            rptr  <= 0;
            widx  <= 0;
            rdata <= '0;
        end else begin
            if (wr_en) begin
                fmem[wptr % 64]    <= wr_data;
                exp_mem[widx % SBN] <= wr_data;
                wptr <= wptr + 1;
                widx <= widx + 1;
            end
            if (rinc) begin
                rdata <= fmem[rptr % 64];
                rptr  <= rptr + 1;
            end
        end
    end

    // Two-word source for the BURST=1 instance.
    logic [15:0] q2 [2];
    int          rp2, n2;

    assign rempty2 = (rp2 >= n2);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp2    <= 0;
            rdata2 <= '0;
        end else if (rinc2) begin
            rdata2 <= q2[rp2 % 2];
            rp2    <= rp2 + 1;
        end
    end

    // Stream monitor: order, framing, hold-while-stalled, no pop on empty.
    int           ridx, acc;
    logic         hold, hold_last;
    logic [W-1:0] hold_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            ridx = 0;
            acc  = 0;
            hold = 1'b0;
        end else begin
            chk("rinc_on_empty", rinc && rempty, 1'b0);
            chk("rinc2_on_empty", rinc2 && rempty2, 1'b0);
            if (hold) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, hold_data);
                chk("hold_last", m_last, hold_last);
            end
            if (m_valid && m_ready) begin
                chk("sb_pending", widx != ridx, 1'b1);
                if (widx != ridx) begin
                    chk("sb_data", m_data, exp_mem[ridx % SBN]);
                    chk("sb_last", m_last, (acc % B) == (B - 1));
                    ridx++;
                    acc++;
                end
            end
            hold      = m_valid && !m_ready;
            hold_data = m_data;
            hold_last = m_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_seq(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            wr_en   = 1'b1;
            wr_data = base + W'(i);
        end
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && (widx != ridx); i++) @(negedge clk);
        chk("drain", widx == ridx, 1'b1);
    endtask

    logic found;
    int   cnt, acc0, sent;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; m_ready = 1'b1; wr_en = 1'b0; wr_data = '0;
        en2 = 1'b1; m_ready2 = 1'b1; n2 = 0;
        q2[0] = 16'hA5A5; q2[1] = 16'h5A5A;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, '0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_rinc", rinc, 1'b0);
        chk("rst_m_valid2", m_valid2, 1'b0);
        step();
        rst_n = 1'b1;

        // 0x01..0x08 streamed back to back, first valid two cycles after rinc
        fork
            write_seq(8'h01, 8);
            begin
                found = 1'b0;
                for (int i = 0; i < 20 && !found; i++) begin
                    @(negedge clk);
                    if (rinc) found = 1'b1;
                end
                chk("t1_rinc_seen", found, 1'b1);
                @(negedge clk);
                chk("t1_latency_gap", m_valid, 1'b0);
                @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("t1_valid", m_valid, 1'b1);
                    chk("t1_data", m_data, W'(i + 1));
                    chk("t1_last", m_last, (i % 4) == 3);
                end
            end
        join
        wait_drain();

        // Stall: six words preloaded, only two pops until the consumer resumes
        m_ready = 1'b0;
        fork
            write_seq(8'h10, 6);
            begin
                cnt = 0;
                repeat (14) begin
                    @(negedge clk);
                    if (rinc) cnt++;
                end
            end
        join
        chk("t2_rinc_pulses", cnt, 2);
        chk("t2_valid", m_valid, 1'b1);
        chk("t2_head", m_data, 8'h10);
        chk("t2_occ", dut.occ, 2'd2);
        step();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_resume_valid", m_valid, 1'b1);
            chk("t2_resume_data", m_data, 8'h10 + W'(i));
        end
        wait_drain();

        // en low with three words waiting: nothing moves until en returns
        step();
        en = 1'b0;
        write_seq(8'h20, 3);
        repeat (5) begin
            @(negedge clk);
            chk("t3_no_rinc", rinc, 1'b0);
            chk("t3_no_valid", m_valid, 1'b0);
        end
        step();
        en = 1'b1;
        @(negedge clk);
        chk("t3_rinc_on_en", rinc, 1'b1);
        @(negedge clk);
        chk("t3_gap", m_valid, 1'b0);
        @(negedge clk);
        chk("t3_valid", m_valid, 1'b1);
        chk("t3_data", m_data, 8'h20);
        wait_drain();

        // Asynchronous reset with a full buffer and a pop in progress
        step();
        m_ready = 1'b0;
        write_seq(8'h30, 4);
        repeat (8) @(negedge clk);
        chk("t4_occ_full", dut.occ, 2'd2);
        chk("t4_stalled_rinc", rinc, 1'b0);
        step();
        m_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", m_valid, 1'b0);
        chk("t4_rst_data", m_data, '0);
        chk("t4_rst_last", m_last, 1'b0);
        chk("t4_rst_rinc", rinc, 1'b0);
        repeat (2) @(negedge clk);
        step();
        rst_n = 1'b1;
        write_seq(8'h40, 8);
        wait_drain();
        chk("t4_words_after_rst", acc, 8);

        // Random traffic: 1000 words, random consumer and enable
        acc0 = acc;
        sent = 0;
        for (int c = 0; c < 20000 && (acc - acc0) < 1000; c++) begin
            step();
            wr_en   = (sent < 1000) && ((wptr - rptr) < 60) && ($urandom_range(0, 99) < 60);
            wr_data = W'($urandom);
            if (wr_en) sent++;
            m_ready = ($urandom_range(0, 1) == 1);
            en      = ($urandom_range(0, 9) != 0);
        end
        step();
        wr_en = 1'b0;
        m_ready = 1'b1;
        en = 1'b1;
        chk("t5_word_count", acc - acc0, 1000);
        wait_drain();

        // BURST=1, WIDTH=16: every word is a frame end
        step();
        n2 = 2;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (m_valid2) found = 1'b1;
        end
        chk("t6_valid", found, 1'b1);
        chk("t6_data0", m_data2, 16'hA5A5);
        chk("t6_last0", m_last2, 1'b1);
        @(negedge clk);
        chk("t6_valid1", m_valid2, 1'b1);
        chk("t6_data1", m_data2, 16'h5A5A);
        chk("t6_last1", m_last2, 1'b1);
        @(negedge clk);
        chk("t6_empty", m_valid2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
